// File: rtl/axi2axilrd.sv
// AXI4 read-burst splitter: turns one AXI4 read burst (FIXED/INCR/WRAP)
// into back-to-back single-beat AXI-lite reads and stitches the lite
// responses back into one AXI4 R burst with RID and RLAST.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an AXI4 AR; arready high
// S_ISSUE | issuing lite ARs; lite responses pass through meanwhile
// S_DRAIN | all lite ARs issued; passing remaining responses through
// S_ERR   | unsupported burst; emitting len+1 SLVERR beats, no lite traffic
module axi2axilrd #(
   parameter int C_AXI_ID_WIDTH   = 2,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 28
) (
   input  logic                        i_clk,
   input  logic                        i_axi_reset_n,
   input  logic                        i_axi_arvalid,
   output logic                        o_axi_arready,
   input  logic [C_AXI_ID_WIDTH-1:0]   i_axi_arid,
   input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
   input  logic [7:0]                  i_axi_arlen,
   input  logic [2:0]                  i_axi_arsize,
   input  logic [1:0]                  i_axi_arburst,
   input  logic [2:0]                  i_axi_arprot,
   output logic                        o_axi_rvalid,
   input  logic                        i_axi_rready,
   output logic [C_AXI_ID_WIDTH-1:0]   o_axi_rid,
   output logic [C_AXI_DATA_WIDTH-1:0] o_axi_rdata,
   output logic [1:0]                  o_axi_rresp,
   output logic                        o_axi_rlast,
   output logic                        o_axil_arvalid,
   input  logic                        i_axil_arready,
   output logic [C_AXI_ADDR_WIDTH-1:0] o_axil_araddr,
   output logic [2:0]                  o_axil_arprot,
   input  logic                        i_axil_rvalid,
   output logic                        o_axil_rready,
   input  logic [C_AXI_DATA_WIDTH-1:0] i_axil_rdata,
   input  logic [1:0]                  i_axil_rresp
);

   localparam int AW = C_AXI_ADDR_WIDTH;
   localparam logic [2:0] MAX_SIZE = 3'($clog2(C_AXI_DATA_WIDTH/8));
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;
   localparam logic [1:0] BURST_RSVD = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ERR} state_t;

   state_t state, state_nxt;

   logic [C_AXI_ID_WIDTH-1:0] r_id;
   logic [AW-1:0]             r_addr;
   logic [7:0]                r_len;
   logic [2:0]                r_size;
   logic [1:0]                r_burst;
   logic [2:0]                r_prot;
   logic [7:0]                iss_cnt;
   logic [7:0]                rsp_cnt;

   logic          ar_hs, lite_ar_hs, r_hs, bad_req;
   logic [AW-1:0] step, wrap_mask, addr_nxt;

   assign ar_hs      = o_axi_arready && i_axi_arvalid;
   assign lite_ar_hs = o_axil_arvalid && i_axil_arready;
   assign r_hs       = o_axi_rvalid && i_axi_rready;

   assign o_axi_rid     = r_id;
   assign o_axil_araddr = r_addr;
   assign o_axil_arprot = r_prot;

   // Classify an incoming burst as one we cannot split (answered with SLVERR)
   always_comb begin
      bad_req = (i_axi_arburst == BURST_RSVD) || (i_axi_arsize > MAX_SIZE);
      if (i_axi_arburst == BURST_WRAP && !(i_axi_arlen == 8'd1 || i_axi_arlen == 8'd3 ||
                                           i_axi_arlen == 8'd7 || i_axi_arlen == 8'd15))
         bad_req = 1'b1;
   end

   // Next beat address; a WRAP burst stays inside its (len+1)*S window
   always_comb begin
      step      = AW'(1) << r_size;
      wrap_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);
      case (r_burst)
         BURST_INCR: addr_nxt = (r_addr & ~(step - AW'(1))) + step;
         BURST_WRAP: addr_nxt = (r_addr & ~wrap_mask) | ((r_addr + step) & wrap_mask);
         default:    addr_nxt = r_addr;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
      if (!i_axi_reset_n) state <= S_IDLE;
      else                state <= state_nxt;
   end

   // Next state and handshake/response outputs; R path is a combinational pass-through
   always_comb begin
      state_nxt      = state;
      o_axi_arready  = 1'b0;
      o_axil_arvalid = 1'b0;
      o_axi_rvalid   = 1'b0;
      o_axil_rready  = 1'b0;
      o_axi_rdata    = '0;
      o_axi_rresp    = 2'b00;
      case (state)
         S_IDLE: begin
            o_axi_arready = 1'b1;
            if (i_axi_arvalid) state_nxt = bad_req ? S_ERR : S_ISSUE;
         end
         S_ISSUE, S_DRAIN: begin
            o_axil_arvalid = (state == S_ISSUE);
            o_axi_rvalid   = i_axil_rvalid;
            o_axil_rready  = i_axi_rready;
            o_axi_rdata    = i_axil_rdata;
            o_axi_rresp    = i_axil_rresp;
            if (state == S_ISSUE && i_axil_arready && iss_cnt == r_len) state_nxt = S_DRAIN;
         end
         S_ERR: begin
            o_axi_rvalid = 1'b1;
            o_axi_rresp  = 2'b10;
         end
         default: state_nxt = S_IDLE;
      endcase
      o_axi_rlast = o_axi_rvalid && (rsp_cnt == r_len);
      if (o_axi_rvalid && i_axi_rready && o_axi_rlast) state_nxt = S_IDLE;
   end

   // Burst context capture, beat address walk and issue/response counters
   always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
      if (!i_axi_reset_n) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_prot  <= '0;
         iss_cnt <= '0;
         rsp_cnt <= '0;
      end else begin
         if (ar_hs) begin
            r_id    <= i_axi_arid;
            r_addr  <= i_axi_araddr;
            r_len   <= i_axi_arlen;
            r_size  <= i_axi_arsize;
            r_burst <= i_axi_arburst;
            r_prot  <= i_axi_arprot;
            iss_cnt <= '0;
            rsp_cnt <= '0;
         end
         if (lite_ar_hs) begin
            iss_cnt <= iss_cnt + 8'd1;
            r_addr  <= addr_nxt;
         end
         if (r_hs) rsp_cnt <= rsp_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi2axilrd.sv
// Bench for axi2axilrd: directed bursts against a bench-side lite slave,
// a burst-level expectation model and literal per-test expectations.
module tb_axi2axilrd;
   localparam int IW = 2;
   localparam int DW = 32;
   localparam int AW = 28;

   logic          i_clk = 1'b0;
   logic          i_axi_reset_n = 1'b0;
   logic          i_axi_arvalid = 1'b0;
   logic          o_axi_arready;
   logic [IW-1:0] i_axi_arid = '0;
   logic [AW-1:0] i_axi_araddr = '0;
   logic [7:0]    i_axi_arlen = '0;
   logic [2:0]    i_axi_arsize = '0;
   logic [1:0]    i_axi_arburst = '0;
   logic [2:0]    i_axi_arprot = '0;
   logic          o_axi_rvalid;
   logic          i_axi_rready = 1'b1;
   logic [IW-1:0] o_axi_rid;
   logic [DW-1:0] o_axi_rdata;
   logic [1:0]    o_axi_rresp;
   logic          o_axi_rlast;
   logic          o_axil_arvalid;
   logic          i_axil_arready = 1'b1;
   logic [AW-1:0] o_axil_araddr;
   logic [2:0]    o_axil_arprot;
   logic          i_axil_rvalid = 1'b0;
   logic          o_axil_rready;
   logic [DW-1:0] i_axil_rdata = '0;
   logic [1:0]    i_axil_rresp = '0;

   axi2axilrd #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) dut (
      .i_clk(i_clk), .i_axi_reset_n(i_axi_reset_n),
      .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready), .i_axi_arid(i_axi_arid),
      .i_axi_araddr(i_axi_araddr), .i_axi_arlen(i_axi_arlen), .i_axi_arsize(i_axi_arsize),
      .i_axi_arburst(i_axi_arburst), .i_axi_arprot(i_axi_arprot),
      .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready), .o_axi_rid(o_axi_rid),
      .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rlast(o_axi_rlast),
      .o_axil_arvalid(o_axil_arvalid), .i_axil_arready(i_axil_arready),
      .o_axil_araddr(o_axil_araddr), .o_axil_arprot(o_axil_arprot),
      .i_axil_rvalid(i_axil_rvalid), .o_axil_rready(o_axil_rready),
      .i_axil_rdata(i_axil_rdata), .i_axil_rresp(i_axil_rresp)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } rbeat_t;

   rbeat_t        exp_r[$];
   rbeat_t        obs_r[$];
   logic [AW-1:0] exp_a[$];
   logic [AW-1:0] obs_a[$];
   logic [AW-1:0] lite_pend[$];

   int checks = 0;
   int passes = 0;

   // stimulus control, written by the main sequence
   bit            ar_pend = 1'b0;
   logic [IW-1:0] ar_id = '0;
   logic [AW-1:0] ar_addr = '0;
   logic [7:0]    ar_len = '0;
   logic [2:0]    ar_size = '0;
   logic [1:0]    ar_burst = '0;
   logic [2:0]    ar_prot = '0;
   int            ar_stall = 0;
   bit            rr_toggle = 1'b0;
   int            slv_err_beat = -1;

   // model state
   bit            busy = 1'b0;
   bit            cur_err = 1'b0;
   logic [2:0]    cur_prot = '0;
   logic [7:0]    rsp_serial = '0;
   int            lite_idx = 0;
   bit            prev_ar_stall = 1'b0;
   bit            prev_r_stall = 1'b0;
   logic [AW-1:0] prev_araddr = '0;
   logic [37:0]   prev_rbits = '0;
   rbeat_t        mb;
   rbeat_t        ob;
   logic [AW-1:0] ma;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Beat k address of a burst, written directly from the AXI address rules
   function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int len,
                                               input int size, input logic [1:0] burst, input int k);
      longint s, ws, st;
      st = longint'(a);
      s  = longint'(1) << size;
      case (burst)
         2'b00:   return a;
         2'b01:   return (k == 0) ? a : AW'((st / s) * s + longint'(k) * s);
         default: begin
            ws = longint'(len + 1) * s;
            return AW'(st - (st % ws) + ((st % ws) + longint'(k) * s) % ws);
         end
      endcase
   endfunction

   // Drive all inputs on the falling edge: AXI master stimulus plus the lite slave
   always @(negedge i_clk) begin
      i_axi_arvalid  = ar_pend;
      i_axi_arid     = ar_id;
      i_axi_araddr   = ar_addr;
      i_axi_arlen    = ar_len;
      i_axi_arsize   = ar_size;
      i_axi_arburst  = ar_burst;
      i_axi_arprot   = ar_prot;
      i_axil_arready = (ar_stall == 0);
      if (ar_stall > 0) ar_stall--;
      i_axi_rready   = rr_toggle ? ~i_axi_rready : 1'b1;
      i_axil_rvalid  = (lite_pend.size() > 0);
      if (lite_pend.size() > 0) begin
         i_axil_rdata = {rsp_serial, lite_pend[0][23:0]};
         i_axil_rresp = (lite_idx == slv_err_beat) ? 2'b10 : 2'b00;
      end else begin
         i_axil_rdata = '0;
         i_axil_rresp = 2'b00;
      end
   end

   // Compare process: observe handshakes shortly after inputs settle, check against the model
   always @(negedge i_clk) begin
      #1;
      if (!i_axi_reset_n) begin
         prev_ar_stall = 1'b0;
         prev_r_stall  = 1'b0;
      end else begin
         chk("arready", o_axi_arready, !busy);
         if (!busy) chk("idle_rvalid", o_axi_rvalid, 1'b0);
         else if (cur_err) begin
            chk("err_rvalid", o_axi_rvalid, 1'b1);
            chk("err_lite_rready", o_axil_rready, 1'b0);
         end else begin
            chk("rvalid_pass", o_axi_rvalid, i_axil_rvalid);
            chk("rready_pass", o_axil_rready, i_axi_rready);
         end
         if (prev_ar_stall) begin
            chk("ar_hold_valid", o_axil_arvalid, 1'b1);
            chk("ar_hold_addr", o_axil_araddr, prev_araddr);
         end
         if (prev_r_stall)
            chk("r_hold", {o_axi_rvalid, o_axi_rlast, o_axi_rresp, o_axi_rdata, o_axi_rid}, prev_rbits);

         if (o_axil_arvalid && i_axil_arready) begin
            obs_a.push_back(o_axil_araddr);
            chk("lite_ar_expected", exp_a.size() > 0, 1'b1);
            if (exp_a.size() > 0) chk("lite_araddr", o_axil_araddr, exp_a.pop_front());
            chk("lite_arprot", o_axil_arprot, cur_prot);
            lite_pend.push_back(o_axil_araddr);
         end
         if (o_axi_rvalid && i_axi_rready) begin
            ob.id = o_axi_rid; ob.data = o_axi_rdata; ob.resp = o_axi_rresp; ob.last = o_axi_rlast;
            obs_r.push_back(ob);
            chk("r_expected", exp_r.size() > 0, 1'b1);
            if (exp_r.size() > 0) begin
               mb = exp_r.pop_front();
               chk("rid", o_axi_rid, mb.id);
               chk("rdata", o_axi_rdata, mb.data);
               chk("rresp", o_axi_rresp, mb.resp);
               chk("rlast", o_axi_rlast, mb.last);
               if (mb.last) busy = 1'b0;
            end
         end
         if (o_axil_rready && i_axil_rvalid) begin
            void'(lite_pend.pop_front());
            rsp_serial++;
            lite_idx++;
         end
         if (i_axi_arvalid && o_axi_arready) begin
            cur_err = (i_axi_arburst == 2'b11) || (i_axi_arsize > 3'd2) ||
                      (i_axi_arburst == 2'b10 && !(i_axi_arlen == 8'd1 || i_axi_arlen == 8'd3 ||
                                                   i_axi_arlen == 8'd7 || i_axi_arlen == 8'd15));
            cur_prot = i_axi_arprot;
            for (int k = 0; k <= int'(i_axi_arlen); k++) begin
               ma = beat_addr(i_axi_araddr, int'(i_axi_arlen), int'(i_axi_arsize), i_axi_arburst, k);
               if (!cur_err) exp_a.push_back(ma);
               mb.id   = i_axi_arid;
               mb.last = (k == int'(i_axi_arlen));
               mb.data = cur_err ? '0 : {rsp_serial + 8'(k), ma[23:0]};
               mb.resp = (cur_err || k == slv_err_beat) ? 2'b10 : 2'b00;
               exp_r.push_back(mb);
            end
            lite_idx = 0;
            busy     = 1'b1;
            ar_pend  = 1'b0;
         end
         prev_ar_stall = o_axil_arvalid && !i_axil_arready;
         prev_araddr   = o_axil_araddr;
         prev_r_stall  = o_axi_rvalid && !i_axi_rready;
         prev_rbits    = {o_axi_rvalid, o_axi_rlast, o_axi_rresp, o_axi_rdata, o_axi_rid};
      end
   end

   task automatic start_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                              input int errb, input int stall, input bit tog);
      obs_a.delete();
      obs_r.delete();
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_prot = prot;
      slv_err_beat = errb;
      ar_stall     = stall;
      rr_toggle    = tog;
      ar_pend      = 1'b1;
   endtask

   task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                           input int errb, input int stall, input bit tog);
      int n;
      start_burst(id, addr, len, size, burst, prot, errb, stall, tog);
      n = 0;
      do begin
         @(posedge i_clk); #2;
         n++;
      end while ((ar_pend || busy) && n < 400);
      chk("burst_done", ar_pend || busy, 1'b0);
      chk("exp_a_drained", exp_a.size(), 0);
      chk("exp_r_drained", exp_r.size(), 0);
      rr_toggle = 1'b0;
   endtask

   logic [AW-1:0] lit4[4];
   int            nlast;

   initial begin
      repeat (3) @(posedge i_clk);
      #2;
      chk("rst_arready", o_axi_arready, 1'b1);
      chk("rst_lite_arvalid", o_axil_arvalid, 1'b0);
      chk("rst_rvalid", o_axi_rvalid, 1'b0);
      chk("rst_rlast", o_axi_rlast, 1'b0);
      chk("rst_araddr", o_axil_araddr, 0);
      i_axi_reset_n = 1'b1;
      @(posedge i_clk); #2;

      // INCR, id 2, 0x100, len 3, size 2
      do_burst(2'd2, 28'h100, 8'd3, 3'd2, 2'b01, 3'd5, -1, 0, 1'b0);
      lit4 = '{28'h100, 28'h104, 28'h108, 28'h10C};
      chk("t1_nlite", obs_a.size(), 4);
      chk("t1_nbeat", obs_r.size(), 4);
      if (obs_a.size() == 4) for (int i = 0; i < 4; i++) chk("t1_addr", obs_a[i], lit4[i]);
      if (obs_r.size() == 4) for (int i = 0; i < 4; i++) begin
         chk("t1_rid", obs_r[i].id, 2'd2);
         chk("t1_rlast", obs_r[i].last, i == 3);
         chk("t1_rdata_lo", obs_r[i].data[23:0], lit4[i][23:0]);
      end

      // WRAP, 0x10C, len 3, size 2
      do_burst(2'd1, 28'h10C, 8'd3, 3'd2, 2'b10, 3'd1, -1, 0, 1'b0);
      lit4 = '{28'h10C, 28'h100, 28'h104, 28'h108};
      chk("t2_nlite", obs_a.size(), 4);
      if (obs_a.size() == 4) for (int i = 0; i < 4; i++) chk("t2_wrap_addr", obs_a[i], lit4[i]);

      // INCR from unaligned 0x102, size 2, len 1
      do_burst(2'd0, 28'h102, 8'd1, 3'd2, 2'b01, 3'd0, -1, 0, 1'b0);
      chk("t2b_nlite", obs_a.size(), 2);
      if (obs_a.size() == 2) begin
         chk("t2b_addr0", obs_a[0], 28'h102);
         chk("t2b_addr1", obs_a[1], 28'h104);
      end

      // FIXED 0x40 len 2, lite SLVERR on beat 2
      do_burst(2'd3, 28'h40, 8'd2, 3'd2, 2'b00, 3'd2, 1, 0, 1'b0);
      chk("t3_nlite", obs_a.size(), 3);
      chk("t3_nbeat", obs_r.size(), 3);
      if (obs_a.size() == 3) for (int i = 0; i < 3; i++) chk("t3_fixed_addr", obs_a[i], 28'h40);
      if (obs_r.size() == 3) begin
         chk("t3_resp0", obs_r[0].resp, 2'b00);
         chk("t3_resp1", obs_r[1].resp, 2'b10);
         chk("t3_resp2", obs_r[2].resp, 2'b00);
      end

      // reserved burst, len 1
      do_burst(2'd1, 28'h80, 8'd1, 3'd2, 2'b11, 3'd0, -1, 0, 1'b0);
      chk("t4_nlite", obs_a.size(), 0);
      chk("t4_nbeat", obs_r.size(), 2);
      if (obs_r.size() == 2) begin
         chk("t4_resp0", obs_r[0].resp, 2'b10);
         chk("t4_resp1", obs_r[1].resp, 2'b10);
         chk("t4_data0", obs_r[0].data, 0);
         chk("t4_data1", obs_r[1].data, 0);
         chk("t4_last0", obs_r[0].last, 1'b0);
         chk("t4_last1", obs_r[1].last, 1'b1);
      end

      // WRAP with len 2 and oversize INCR are both refused
      do_burst(2'd2, 28'h80, 8'd2, 3'd2, 2'b10, 3'd0, -1, 0, 1'b0);
      chk("t4b_nlite", obs_a.size(), 0);
      chk("t4b_nbeat", obs_r.size(), 3);
      do_burst(2'd2, 28'h80, 8'd0, 3'd3, 2'b01, 3'd0, -1, 0, 1'b0);
      chk("t4c_nlite", obs_a.size(), 0);
      chk("t4c_nbeat", obs_r.size(), 1);

      // INCR len 7 with lite arready low 5 ISSUE cycles and rready toggling
      do_burst(2'd1, 28'h200, 8'd7, 3'd2, 2'b01, 3'd3, -1, 6, 1'b1);
      chk("t5_nlite", obs_a.size(), 8);
      chk("t5_nbeat", obs_r.size(), 8);
      nlast = 0;
      if (obs_r.size() == 8) for (int i = 0; i < 8; i++) begin
         chk("t5_addr", obs_a[i], 28'h200 + 28'(4 * i));
         chk("t5_order", obs_r[i].data[23:0], 24'h200 + 24'(4 * i));
         if (obs_r[i].last) nlast++;
      end
      chk("t5_rlast_once", nlast, 1);

      // asynchronous reset mid-ISSUE, then a len-0 burst
      start_burst(2'd1, 28'h400, 8'd7, 3'd2, 2'b01, 3'd0, -1, 0, 1'b0);
      for (int n = 0; n < 100 && obs_a.size() < 3; n++) begin
         @(posedge i_clk); #2;
      end
      chk("t6_started", obs_a.size() >= 3, 1'b1);
      @(negedge i_clk); #2;
      i_axi_reset_n = 1'b0;
      #1;
      chk("t6_lite_arvalid", o_axil_arvalid, 1'b0);
      chk("t6_rvalid", o_axi_rvalid, 1'b0);
      chk("t6_rlast", o_axi_rlast, 1'b0);
      chk("t6_arready", o_axi_arready, 1'b1);
      chk("t6_rid", o_axi_rid, 2'd0);
      chk("t6_araddr", o_axil_araddr, 0);
      ar_pend = 1'b0;
      busy    = 1'b0;
      exp_a.delete();
      exp_r.delete();
      lite_pend.delete();
      repeat (2) @(posedge i_clk);
      #2;
      i_axi_reset_n = 1'b1;
      @(posedge i_clk); #2;
      chk("t6_arready_after", o_axi_arready, 1'b1);
      do_burst(2'd3, 28'h300, 8'd0, 3'd2, 2'b01, 3'd0, -1, 0, 1'b0);
      chk("t6_nlite", obs_a.size(), 1);
      chk("t6_nbeat", obs_r.size(), 1);
      if (obs_r.size() == 1) begin
         chk("t6_addr", obs_a[0], 28'h300);
         chk("t6_last", obs_r[0].last, 1'b1);
         chk("t6_id", obs_r[0].id, 2'd3);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
